// File: rtl/imem_access_controller_pkg.sv
// Shared types and helpers for the instruction-memory access controller.
// Holds the state/requester encodings and the address legality check.
package imem_access_controller_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic {
      IMEM_ST_BOOT = 1'b0,
      IMEM_ST_RUN  = 1'b1
   } imem_state_e;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_LD    = 1'b1
   } req_id_e;

   // A byte address is illegal if misaligned or beyond the last word of the array.
   function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_w);
      logic [31:0] word_idx;
      word_idx = addr >> 2;
      return (addr[1:0] != 2'b00) || ((word_idx >> addr_w) != 32'd0);
   endfunction

endpackage

// File: rtl/imem_access_controller_if.sv
// Bundle of fetch, loader, boot-control and memory-macro signals.
// slave = controller side, master = requesters plus memory macro.
interface imem_access_controller_if #(parameter int unsigned ADDR_W = 12);
   import imem_access_controller_pkg::*;

   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_gnt;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;

   logic              ld_req;
   logic              ld_we;
   logic [31:0]       ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;

   logic              boot_done;
   logic              cpu_stall;
   logic              err;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, boot_done, mem_rdata,
      output fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_rvalid, ld_rdata,
             cpu_stall, err, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, boot_done, mem_rdata,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_rvalid, ld_rdata,
             cpu_stall, err, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_starve_counter.sv
// Saturating count of consecutive cycles the loader was denied the memory port.
// at_max tells the arbiter the loader must win its next request.
module imem_starve_counter #(
   parameter int unsigned MAX = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic at_max
);
   import imem_access_controller_pkg::*;

   localparam logic [7:0] MAX_C = 8'(MAX);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 8'd0;
      end else if (clr) begin
         cnt <= 8'd0;
      end else if (inc && (cnt != MAX_C)) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/imem_access_controller.sv
// Arbitrates the single synchronous-read instruction memory port between fetch and loader.
// Optional IMEM_WRITE_PROTECT_EN: loader writes in RUN are granted but dropped with err.
//
// state        | meaning
// IMEM_ST_BOOT | CPU stalled, only the loader is served; boot_done moves to RUN
// IMEM_ST_RUN  | fetch has priority, starvation counter forces loader grants
module imem_access_controller
   import imem_access_controller_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned STARVE_MAX = 8,
   parameter bit          BOOT_HOLD  = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   imem_access_controller_if.slave  bus
);

   imem_state_e state;
   req_id_e     rsp_id;
   logic        rsp_rd;
   logic        rsp_fault;
   logic        err_q;

   logic        fetch_fault;
   logic        ld_fault;
   logic        fetch_win;
   logic        ld_win;
   logic        wp_block;
   logic        at_max;
   logic        starve_inc;
   logic        rsp_live;

   always_comb begin
      fetch_fault = addr_fault(bus.fetch_addr, ADDR_W);
      ld_fault    = addr_fault(bus.ld_addr, ADDR_W);
      fetch_win   = 1'b0;
      ld_win      = 1'b0;
      if (!reset) begin
         if (state == IMEM_ST_BOOT) begin
            ld_win = bus.ld_req;
         end else if (bus.ld_req && (at_max || !bus.fetch_req)) begin
            ld_win = 1'b1;
         end else begin
            fetch_win = bus.fetch_req;
         end
      end
`ifdef IMEM_WRITE_PROTECT_EN
      wp_block = ld_win && bus.ld_we && (state == IMEM_ST_RUN);
`else
      wp_block = 1'b0;
`endif
      starve_inc = !reset && (state == IMEM_ST_RUN) && bus.ld_req && !ld_win;
   end

   imem_starve_counter #(.MAX(STARVE_MAX)) u_starve (
      .clk    (clk),
      .reset  (reset),
      .clr    (ld_win),
      .inc    (starve_inc),
      .at_max (at_max)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= BOOT_HOLD ? IMEM_ST_BOOT : IMEM_ST_RUN;
         rsp_rd    <= 1'b0;
         rsp_id    <= REQ_FETCH;
         rsp_fault <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if ((state == IMEM_ST_BOOT) && bus.boot_done) begin
            state <= IMEM_ST_RUN;
         end
         rsp_rd    <= fetch_win || (ld_win && !bus.ld_we);
         rsp_id    <= ld_win ? REQ_LD : REQ_FETCH;
         rsp_fault <= ld_win ? ld_fault : fetch_fault;
         err_q     <= (ld_win && (ld_fault || wp_block)) || (fetch_win && fetch_fault);
      end
   end

   assign bus.fetch_gnt = fetch_win;
   assign bus.ld_gnt    = ld_win;
   assign bus.cpu_stall = (state == IMEM_ST_BOOT);

   assign bus.mem_en    = (ld_win && !ld_fault && !wp_block) || (fetch_win && !fetch_fault);
   assign bus.mem_we    = ld_win && !ld_fault && !wp_block && bus.ld_we;
   assign bus.mem_addr  = ld_win    ? bus.ld_addr[ADDR_W+1:2]    :
                          fetch_win ? bus.fetch_addr[ADDR_W+1:2] : '0;
   assign bus.mem_wdata = (ld_win && bus.ld_we) ? bus.ld_wdata : '0;

   // A synchronous reset landing on the response cycle must swallow the response.
   assign rsp_live         = rsp_rd && !reset;
   assign bus.fetch_rvalid = rsp_live && (rsp_id == REQ_FETCH);
   assign bus.ld_rvalid    = rsp_live && (rsp_id == REQ_LD);
   assign bus.fetch_rdata  = (bus.fetch_rvalid && !rsp_fault) ? bus.mem_rdata : '0;
   assign bus.ld_rdata     = (bus.ld_rvalid && !rsp_fault) ? bus.mem_rdata : '0;
   assign bus.err          = err_q && !reset;

endmodule

// File: tb/tb_imem_access_controller.sv
// Scoreboard bench for imem_access_controller: directed boot/starve/fault/reset
// sequences followed by randomized traffic against a behavioural model.
module tb_imem_access_controller;

   localparam int ADDR_W     = 12;
   localparam int STARVE_MAX = 8;
   localparam int DEPTH      = 1 << ADDR_W;

   typedef struct {
      int          due;
      logic        fv;
      logic        lv;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imem_access_controller_if #(.ADDR_W(ADDR_W)) bus ();

   imem_access_controller #(
      .ADDR_W     (ADDR_W),
      .STARVE_MAX (STARVE_MAX),
      .BOOT_HOLD  (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem_array [0:DEPTH-1];

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem_array[bus.mem_addr];
      end
   end

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_on = 0;
   bit   booted = 0;
   int   streak = 0;
   logic s_fgnt, s_lgnt;
   logic [31:0] ref_mem [int unsigned];
   exp_t q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_rd(input int unsigned idx);
      return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
   endfunction

   function automatic bit bad_addr(input logic [31:0] a);
      return ((a % 4) != 0) || ((a / 4) >= 32'(DEPTH));
   endfunction

   // One clock of stimulus; expectations come from the access rules, not the RTL.
   task automatic step(input logic rst, input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] lwd, input logic bd);
      bit   give_ld, give_f, fault, blocked, exp_en, exp_we;
      logic [31:0] exp_addr;
      exp_t e;
      @(posedge clk);
      #1;
      reset          = rst;
      bus.fetch_req  = fr;
      bus.fetch_addr = fa;
      bus.ld_req     = lr;
      bus.ld_we      = lw;
      bus.ld_addr    = la;
      bus.ld_wdata   = lwd;
      bus.boot_done  = bd;
      if (rst) q.delete();
      @(negedge clk);
      s_fgnt = bus.fetch_gnt;
      s_lgnt = bus.ld_gnt;
      if (rst) begin
         chk("rst_fetch_gnt", {31'b0, bus.fetch_gnt}, 0);
         chk("rst_ld_gnt", {31'b0, bus.ld_gnt}, 0);
         chk("rst_mem_en", {31'b0, bus.mem_en}, 0);
         booted = 0;
         streak = 0;
         return;
      end
      give_ld = 0;
      give_f  = 0;
      if (!booted) give_ld = lr;
      else if (lr && (streak >= STARVE_MAX || !fr)) give_ld = 1;
      else give_f = fr;
      fault   = give_ld ? bad_addr(la) : (give_f ? bad_addr(fa) : 0);
`ifdef IMEM_WRITE_PROTECT_EN
      blocked = give_ld && lw && booted;
`else
      blocked = 0;
`endif
      exp_en   = (give_ld || give_f) && !fault && !blocked;
      exp_we   = exp_en && give_ld && lw;
      exp_addr = give_ld ? (la / 4) % DEPTH : (give_f ? (fa / 4) % DEPTH : 0);
      chk("cpu_stall", {31'b0, bus.cpu_stall}, {31'b0, !booted});
      chk("fetch_gnt", {31'b0, bus.fetch_gnt}, {31'b0, give_f});
      chk("ld_gnt", {31'b0, bus.ld_gnt}, {31'b0, give_ld});
      chk("mem_en", {31'b0, bus.mem_en}, {31'b0, exp_en});
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_we});
      if (exp_en || !(give_ld || give_f))
         chk("mem_addr", 32'(bus.mem_addr), exp_addr);
      if (exp_we) chk("mem_wdata", bus.mem_wdata, lwd);
      e.due = cyc + 1;
      e.fv  = 0;
      e.lv  = 0;
      e.err = fault || blocked;
      e.data = 0;
      if (give_f || (give_ld && !lw)) begin
         e.fv   = give_f;
         e.lv   = give_ld;
         e.data = fault ? 32'h0 : ref_rd((give_f ? fa : la) / 4);
         q.push_back(e);
      end else if (give_ld && lw) begin
         if (fault || blocked) q.push_back(e);
         else ref_mem[la / 4] = lwd;
      end
      if (booted && lr && !give_ld && streak < STARVE_MAX) streak++;
      if (give_ld) streak = 0;
      if (!booted && bd) booted = 1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      logic any;
      if (mon_on) begin
         any = bus.fetch_rvalid || bus.ld_rvalid || bus.err;
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("fetch_rvalid", {31'b0, bus.fetch_rvalid}, {31'b0, e.fv});
            chk("ld_rvalid", {31'b0, bus.ld_rvalid}, {31'b0, e.lv});
            chk("err", {31'b0, bus.err}, {31'b0, e.err});
            if (e.fv) chk("fetch_rdata", bus.fetch_rdata, e.data);
            if (e.lv) chk("ld_rdata", bus.ld_rdata, e.data);
         end else begin
            chk("no_response", {31'b0, any}, 0);
         end
      end
   end

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      if (r == 1) return 32'h4000 + (32'($urandom_range(0, 1023)) << 2);
      return 32'($urandom_range(0, 31)) << 2;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, second;
      for (int i = 0; i < DEPTH; i++) mem_array[i] = 32'h0;
      bus.mem_rdata  = 32'h0;
      bus.fetch_req  = 0;
      bus.fetch_addr = 0;
      bus.ld_req     = 0;
      bus.ld_we      = 0;
      bus.ld_addr    = 0;
      bus.ld_wdata   = 0;
      bus.boot_done  = 0;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      mon_on = 1;
      chk("reset_stall", {31'b0, bus.cpu_stall}, 1);
      // Boot fill with fetch held high
      step(0, 1, 32'h4, 1, 1, 32'h0, 32'h00000013, 0);
      step(0, 1, 32'h4, 1, 1, 32'h4, 32'h00100093, 0);
      step(0, 1, 32'h4, 0, 0, 0, 0, 1);
      step(0, 1, 32'h4, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // Starvation: loader denied STARVE_MAX cycles, then forced
      first = 0;
      second = 0;
      for (int i = 1; i <= 20; i++) begin
         step(0, 1, 32'h10, 1, 0, 32'h0, 0, 0);
         if (s_lgnt) begin
            if (first == 0) first = i;
            else if (second == 0) second = i;
         end
      end
      chk("starve_first_grant", first, STARVE_MAX + 1);
      chk("starve_regrant_gap", second - first, STARVE_MAX + 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // Faults
      step(0, 1, 32'h2, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 32'h4000, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // Write protect (or ordinary write when the feature is off)
      step(0, 0, 0, 1, 1, 32'h8, 32'hDEADBEEF, 0);
      step(0, 0, 0, 1, 0, 32'h8, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // Reset landing on the response cycle of a fetch
      step(0, 1, 32'h4, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("post_reset_stall", {31'b0, bus.cpu_stall}, 1);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0,
              1'($urandom_range(0, 1)), rand_addr(),
              $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand_addr(),
              $urandom, $urandom_range(0, 15) == 0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
